// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release (mem->periph->core) and reverse-order software reset drain
module reset_sequencer #(
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_GAP    = 8,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic i_aclk,
  input  logic i_areset_n,
  input  logic i_sw_rst_req,
  input  logic i_mem_init_done,
  output logic o_mem_rst_n,
  output logic o_periph_rst_n,
  output logic o_core_rst_n,
  output logic o_rst_busy,
  output logic o_sw_rst_ack,
  output logic o_init_timeout
);
  localparam int MAX_HG = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_V  = MAX_HG > INIT_TIMEOUT ? MAX_HG : INIT_TIMEOUT;
  localparam int CW     = $clog2(MAX_V + 1);
  typedef enum logic [2:0] {HOLD, WAIT_INIT, REL_GAP, RUN, DRAIN_P, DRAIN_M} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic mem_d, periph_d, core_d, busy_d, ack_d, tmo_d;
  logic hold_end, gap_end, init_end;
  assign hold_end = cnt == CW'(HOLD_CYCLES - 1);
  assign gap_end  = cnt == CW'(STAGE_GAP - 1);
  assign init_end = cnt == CW'(INIT_TIMEOUT - 1);
  always_comb begin
    state_d  = state;
    mem_d    = o_mem_rst_n;
    periph_d = o_periph_rst_n;
    core_d   = o_core_rst_n;
    busy_d   = o_rst_busy;
    ack_d    = 1'b0;
    tmo_d    = o_init_timeout;
    case (state)
      HOLD: if (hold_end) begin
        mem_d   = 1'b1;
        state_d = WAIT_INIT;
      end
      WAIT_INIT: if (i_mem_init_done || init_end) begin
        periph_d = 1'b1;
        tmo_d    = !i_mem_init_done;
        state_d  = REL_GAP;
      end
      REL_GAP: if (gap_end) begin
        core_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = RUN;
      end
      RUN: if (i_sw_rst_req) begin
        core_d  = 1'b0;
        busy_d  = 1'b1;
        ack_d   = 1'b1;
        state_d = DRAIN_P;
      end
      DRAIN_P: if (gap_end) begin
        periph_d = 1'b0;
        state_d  = DRAIN_M;
      end
      DRAIN_M: if (gap_end) begin
        mem_d   = 1'b0;
        state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
    cnt_d = (state_d != state || state == RUN) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state          <= HOLD;
      cnt            <= '0;
      o_mem_rst_n    <= 1'b0;
      o_periph_rst_n <= 1'b0;
      o_core_rst_n   <= 1'b0;
      o_rst_busy     <= 1'b1;
      o_sw_rst_ack   <= 1'b0;
      o_init_timeout <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      o_mem_rst_n    <= mem_d;
      o_periph_rst_n <= periph_d;
      o_core_rst_n   <= core_d;
      o_rst_busy     <= busy_d;
      o_sw_rst_ack   <= ack_d;
      o_init_timeout <= tmo_d;
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of release/drain timing, timeout, and async reset
module tb_reset_sequencer;
  logic i_aclk = 1'b0;
  logic i_areset_n = 1'b0;
  logic i_sw_rst_req = 1'b0;
  logic i_mem_init_done = 1'b0;
  logic o_mem_rst_n, o_periph_rst_n, o_core_rst_n, o_rst_busy, o_sw_rst_ack, o_init_timeout;
  logic [5:0] outs;
  int total = 0;
  int bad = 0;
  int e = 0;
  int ack_cnt = 0;
  reset_sequencer dut (
    .i_aclk(i_aclk),
    .i_areset_n(i_areset_n),
    .i_sw_rst_req(i_sw_rst_req),
    .i_mem_init_done(i_mem_init_done),
    .o_mem_rst_n(o_mem_rst_n),
    .o_periph_rst_n(o_periph_rst_n),
    .o_core_rst_n(o_core_rst_n),
    .o_rst_busy(o_rst_busy),
    .o_sw_rst_ack(o_sw_rst_ack),
    .o_init_timeout(o_init_timeout)
  );
  always #5 i_aclk = ~i_aclk;
  assign outs = {o_mem_rst_n, o_periph_rst_n, o_core_rst_n, o_rst_busy, o_sw_rst_ack, o_init_timeout};
  always @(negedge i_aclk) if (o_sw_rst_ack) ack_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // advance to 1ns after edge k of the current release
  task automatic run_to(input int k);
    while (e < k) begin
      @(posedge i_aclk);
      e++;
    end
    #1;
  endtask
  task automatic release_rst();
    @(negedge i_aclk);
    i_areset_n = 1'b1;
    e = 0;
  endtask
  task automatic async_rst(input string tag);
    i_areset_n = 1'b0;
    #2;
    check(tag, 32'(outs), 32'b000100);
    @(negedge i_aclk);
  endtask
  initial begin
    // outs = {mem, periph, core, busy, ack, timeout}
    repeat (3) @(posedge i_aclk);
    #1;
    check("por_reset", 32'(outs), 32'b000100);
    i_mem_init_done = 1'b1;
    release_rst();
    run_to(15); check("p_e15", 32'(outs), 32'b000100);
    run_to(16); check("p_e16", 32'(outs), 32'b100100);
    run_to(17); check("p_e17", 32'(outs), 32'b110100);
    run_to(24); check("p_e24", 32'(outs), 32'b110100);
    run_to(25); check("p_e25", 32'(outs), 32'b111000);
    async_rst("rst_run");
    i_mem_init_done = 1'b0;
    release_rst();
    run_to(39); check("d_e39", 32'(outs), 32'b100100);
    i_mem_init_done = 1'b1;
    run_to(40); check("d_e40", 32'(outs), 32'b110100);
    run_to(47); check("d_e47", 32'(outs), 32'b110100);
    run_to(48); check("d_e48", 32'(outs), 32'b111000);
    run_to(99);
    ack_cnt = 0;
    i_sw_rst_req = 1'b1;
    run_to(100); check("s_e100", 32'(outs), 32'b110110);
    i_sw_rst_req = 1'b0;
    run_to(101); check("s_e101", 32'(outs), 32'b110100);
    run_to(107); check("s_e107", 32'(outs), 32'b110100);
    run_to(108); check("s_e108", 32'(outs), 32'b100100);
    run_to(115); check("s_e115", 32'(outs), 32'b100100);
    run_to(116); check("s_e116", 32'(outs), 32'b000100);
    run_to(131); check("s_e131", 32'(outs), 32'b000100);
    run_to(132); check("s_e132", 32'(outs), 32'b100100);
    run_to(133); check("s_e133", 32'(outs), 32'b110100);
    run_to(140); check("s_e140", 32'(outs), 32'b110100);
    run_to(141); check("s_e141", 32'(outs), 32'b111000);
    check("s_acks", 32'(ack_cnt), 32'd1);
    async_rst("rst_after_sw");
    ack_cnt = 0;
    i_sw_rst_req = 1'b1;
    release_rst();
    run_to(25); check("h_e25", 32'(outs), 32'b111000);
    check("h_noack", 32'(ack_cnt), 32'd0);
    run_to(26); check("h_e26", 32'(outs), 32'b110110);
    i_sw_rst_req = 1'b0;
    run_to(27); check("h_e27", 32'(outs), 32'b110100);
    check("h_acks", 32'(ack_cnt), 32'd1);
    async_rst("rst_drain");
    i_mem_init_done = 1'b0;
    release_rst();
    run_to(1039); check("t_e1039", 32'(outs), 32'b100100);
    run_to(1040); check("t_e1040", 32'(outs), 32'b110101);
    run_to(1047); check("t_e1047", 32'(outs), 32'b110101);
    run_to(1048); check("t_e1048", 32'(outs), 32'b111001);
    i_mem_init_done = 1'b1;
    run_to(1049);
    i_sw_rst_req = 1'b1;
    run_to(1050); check("t_e1050", 32'(outs), 32'b110111);
    i_sw_rst_req = 1'b0;
    run_to(1066); check("t_e1066", 32'(outs), 32'b000101);
    run_to(1082); check("t_e1082", 32'(outs), 32'b100101);
    run_to(1083); check("t_e1083", 32'(outs), 32'b110100);
    run_to(1091); check("t_e1091", 32'(outs), 32'b111000);
    run_to(1092);
    i_sw_rst_req = 1'b1;
    run_to(1093); check("r_e1093", 32'(outs), 32'b110110);
    i_sw_rst_req = 1'b0;
    run_to(1097); check("r_drain_p", 32'(outs), 32'b110100);
    async_rst("rst_in_drain_p");
    release_rst();
    run_to(15); check("r1_e15", 32'(outs), 32'b000100);
    run_to(16); check("r1_e16", 32'(outs), 32'b100100);
    run_to(25); check("r1_e25", 32'(outs), 32'b111000);
    async_rst("rst_in_run");
    release_rst();
    run_to(20); check("r2_rel_gap", 32'(outs), 32'b110100);
    async_rst("rst_in_rel_gap");
    release_rst();
    run_to(15); check("r3_e15", 32'(outs), 32'b000100);
    run_to(16); check("r3_e16", 32'(outs), 32'b100100);
    run_to(17); check("r3_e17", 32'(outs), 32'b110100);
    run_to(25); check("r3_e25", 32'(outs), 32'b111000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
